store_write_buffer: RTL and testbench

//  Parametrised posted-write FIFO between the 6502 core and the BRAM/vector-memory address decoder.

---
 rtl/core_if_pkg.sv | 17 +
 rtl/store_fwd_match.sv | 36 +++
 rtl/store_write_buffer.sv | 134 +++++++++++++
 tb/tb_store_write_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_if_pkg.sv
// Shared core-interface types and defaults for the 6502 store path.
package core_if_pkg;

    localparam int CORE_DATA_W = 8;
    localparam int CORE_ADDR_W = 16;
    localparam int STQ_DEPTH   = 32;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] data;
    } store_entry_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Age-ordered store-to-load match: scans entries oldest to youngest so the
// youngest valid entry whose address equals lookup_addr supplies the data.
module store_fwd_match
    import core_if_pkg::*;
#(
    parameter int DEPTH  = STQ_DEPTH,
    parameter int ADDR_W = CORE_ADDR_W,
    parameter int DATA_W = CORE_DATA_W
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [ADDR_W-1:0]        entry_addr [DEPTH],
    input  logic [DATA_W-1:0]        entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid[idx] && (entry_addr[idx] == lookup_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the 6502 core and the memory decoder.
// Optional store-to-load forwarding is built when STORE_FWD_EN is defined.
module store_write_buffer
    import core_if_pkg::*;
#(
    parameter int DATA_W = CORE_DATA_W,
    parameter int ADDR_W = CORE_ADDR_W,
    parameter int DEPTH  = STQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          D,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       we,
    input  logic                       canWrite,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          lookupAddr,
    output logic [DATA_W-1:0]          Q,
    output logic [ADDR_W-1:0]          writeAddr,
    output logic                       writeOut,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       fwdHit,
    output logic [DATA_W-1:0]          fwdData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("store_write_buffer: DEPTH must be a power of 2 and >= 2");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             we_last;
    logic             push_req;
    logic             push_ok;
    logic             push_drop;
    logic             pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign push_req  = we & ~we_last;
    assign pop       = canWrite & ~empty & ~flush;
    // When full, a push only fits if the head leaves in the same cycle.
    assign push_ok   = push_req & ~flush & (~full | pop);
    assign push_drop = push_req & ~flush & full & ~pop;

    assign writeOut  = pop;
    assign Q         = empty ? '0 : mem[rd_ptr].data;
    assign writeAddr = empty ? '0 : mem[rd_ptr].addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            we_last  <= 1'b0;
        end else begin
            we_last <= we;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      count <= count + 1'b1;
                else if (pop && !push_ok) count <= count - 1'b1;
                if (push_drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr].addr <= addr;
            mem[wr_ptr].data <= D;
        end
    end

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            // Set after clear: a full-queue push+pop reuses the same slot.
            if (pop)     valid[rd_ptr] <= 1'b0;
            if (push_ok) valid[wr_ptr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_addr[g] = mem[g].addr;
        assign ent_data[g] = mem[g].data;
    end

    store_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .valid       (valid),
        .entry_addr  (ent_addr),
        .entry_data  (ent_data),
        .rd_ptr      (rd_ptr),
        .lookup_addr (lookupAddr),
        .hit         (fwdHit),
        .data        (fwdData)
    );
`else
    logic unused_lookup;
    assign unused_lookup = ^lookupAddr;
    assign fwdHit        = 1'b0;
    assign fwdData       = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_store_write_buffer;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  D = '0;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic        canWrite = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] lookupAddr = '0;
    logic [7:0]  Q;
    logic [15:0] writeAddr;
    logic        writeOut;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        fwdHit;
    logic [7:0]  fwdData;

    store_write_buffer #(.DATA_W(8), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .D(D), .addr(addr), .we(we), .canWrite(canWrite),
        .flush(flush), .lookupAddr(lookupAddr), .Q(Q), .writeAddr(writeAddr),
        .writeOut(writeOut), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .fwdHit(fwdHit), .fwdData(fwdData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t mq[$];
    bit   m_we_last;
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        bit          w;
        bit          cw;
        bit          fl;
        logic [15:0] a;
        logic [7:0]  d;
        int          e_cnt;
        bit          e_wo;
        logic [7:0]  e_q;
        logic [15:0] e_wa;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_we_last = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic drive(input bit w, input bit cw, input bit fl,
                         input logic [15:0] a, input logic [7:0] d, input logic [15:0] la);
        @(negedge clk);
        we = w; canWrite = cw; flush = fl; addr = a; D = d; lookupAddr = la;
        #1;
    endtask

    task automatic check_model();
        int          sz;
        bit          hit;
        logic [7:0]  fd;
        sz  = mq.size();
        hit = 1'b0;
        fd  = '0;
`ifdef STORE_FWD_EN
        for (int i = 0; i < sz; i++)
            if (mq[i].a == lookupAddr) begin
                hit = 1'b1;
                fd  = mq[i].d;
            end
`endif
        check("writeOut", 32'(writeOut), 32'(canWrite && sz > 0 && !flush));
        check("Q", 32'(Q), (sz > 0) ? 32'(mq[0].d) : 32'd0);
        check("writeAddr", 32'(writeAddr), (sz > 0) ? 32'(mq[0].a) : 32'd0);
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("fwdHit", 32'(fwdHit), 32'(hit));
        check("fwdData", 32'(fwdData), 32'(fd));
    endtask

    task automatic advance();
        int sz;
        bit push;
        bit pop;
        sz   = mq.size();
        push = we && !m_we_last;
        pop  = canWrite && sz > 0 && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) mq.push_back('{a: addr, d: D});
                else m_ovf = 1'b1;
            end
        end
        m_we_last = we;
        @(posedge clk);
    endtask

    task automatic step(input bit w, input bit cw, input bit fl,
                        input logic [15:0] a, input logic [7:0] d, input logic [15:0] la);
        drive(w, cw, fl, a, d, la);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        we = 0; canWrite = 0; flush = 0; addr = '0; D = '0; lookupAddr = '0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic fill_32();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0, 16'h1000 + 16'(i), 8'(i), 16'h0);
            step(0, 0, 0, 16'h0, 8'h0, 16'h0);
        end
    endtask

    initial begin
        vec[0]  = '{1, 0, 0, 16'h0200, 8'h5A, 0, 0, 8'h00, 16'h0000};
        vec[1]  = '{1, 0, 0, 16'h0200, 8'h5A, 1, 0, 8'h5A, 16'h0200};
        vec[2]  = '{1, 0, 0, 16'h0200, 8'h5A, 1, 0, 8'h5A, 16'h0200};
        vec[3]  = '{1, 0, 0, 16'h0200, 8'h5A, 1, 0, 8'h5A, 16'h0200};
        vec[4]  = '{1, 0, 0, 16'h0200, 8'h5A, 1, 0, 8'h5A, 16'h0200};
        vec[5]  = '{0, 1, 0, 16'h0000, 8'h00, 1, 1, 8'h5A, 16'h0200};
        vec[6]  = '{0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000};
        vec[7]  = '{1, 1, 0, 16'h0300, 8'h11, 0, 0, 8'h00, 16'h0000};
        vec[8]  = '{1, 0, 0, 16'h0300, 8'h11, 1, 0, 8'h11, 16'h0300};
        vec[9]  = '{0, 1, 1, 16'h0000, 8'h00, 1, 0, 8'h11, 16'h0300};
        vec[10] = '{0, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000};

        model_clear();
        #12;
        rst = 1'b0;

        // Reset values
        drive(0, 0, 0, 16'h0, 8'h0, 16'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check_model();
        advance();

        // Held strobe, single pop, empty canWrite, flush blocking pop
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(vec[i].w, vec[i].cw, vec[i].fl, vec[i].a, vec[i].d, 16'h0);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vec[i].e_cnt));
            check($sformatf("vec%0d_wout", i), 32'(writeOut), 32'(vec[i].e_wo));
            check($sformatf("vec%0d_q", i), 32'(Q), 32'(vec[i].e_q));
            check($sformatf("vec%0d_waddr", i), 32'(writeAddr), 32'(vec[i].e_wa));
            check_model();
            advance();
        end

        // Asynchronous reset while draining
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 16'h0400 + 16'(i), 8'h40 + 8'(i), 16'h0);
            step(0, 0, 0, 16'h0, 8'h0, 16'h0);
        end
        drive(0, 1, 0, 16'h0, 8'h0, 16'h0);
        check("mid_drain_wout", 32'(writeOut), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_wout", 32'(writeOut), 32'd0);
        check("async_rst_q", 32'(Q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        canWrite = 1'b0;
        model_clear();

        // Fill, overflow on 33rd push, then drain in order
        fill_32();
        step(1, 0, 0, 16'h1FFF, 8'h77, 16'h0);
        drive(0, 0, 0, 16'h0, 8'h0, 16'h0);
        check("ovf_count", 32'(count), 32'd32);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 16'h0, 8'h0, 16'h0);
            check("drain_q", 32'(Q), 32'(i));
            check_model();
            advance();
        end
        drive(0, 0, 0, 16'h0, 8'h0, 16'h0);
        check("drained_empty", 32'(empty), 32'd1);
        advance();

        // Flush with simultaneous push; overflow from the previous test persists
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 16'h0500 + 16'(i), 8'h50 + 8'(i), 16'h0);
            step(0, 0, 0, 16'h0, 8'h0, 16'h0);
        end
        drive(1, 1, 1, 16'h05FF, 8'hEE, 16'h0);
        check("flush_wout", 32'(writeOut), 32'd0);
        check_model();
        advance();
        drive(0, 0, 0, 16'h0, 8'h0, 16'h0);
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_wout", 32'(writeOut), 32'd0);
        check("post_flush_ovf", 32'(overflow), 32'd1);
        check_model();
        advance();

        // Full push+pop in the same cycle
        do_reset();
        fill_32();
        drive(1, 1, 0, 16'h3AAA, 8'hAA, 16'h0);
        check("fullpp_popped_q", 32'(Q), 32'd0);
        check_model();
        advance();
        drive(0, 0, 0, 16'h0, 8'h0, 16'h0);
        check("fullpp_count", 32'(count), 32'd32);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 16'h0, 8'h0, 16'h0);
            if (i == DEPTH - 1) check("fullpp_last_q", 32'(Q), 32'hAA);
            check_model();
            advance();
        end

        // Forwarding: youngest match wins
        do_reset();
        step(1, 0, 0, 16'h2010, 8'h11, 16'h0);
        step(0, 0, 0, 16'h0, 8'h0, 16'h0);
        step(1, 0, 0, 16'h2010, 8'h22, 16'h2010);
        step(0, 0, 0, 16'h0, 8'h0, 16'h0);
        drive(0, 0, 0, 16'h0, 8'h0, 16'h2010);
`ifdef STORE_FWD_EN
        check("fwd_hit", 32'(fwdHit), 32'd1);
        check("fwd_data", 32'(fwdData), 32'h22);
`else
        check("fwd_hit_off", 32'(fwdHit), 32'd0);
        check("fwd_data_off", 32'(fwdData), 32'd0);
`endif
        advance();
        drive(0, 0, 0, 16'h0, 8'h0, 16'h2011);
        check("fwd_miss", 32'(fwdHit), 32'd0);
        check_model();
        advance();

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit cw;
            case ((i / 100) % 4)
                0:       cw = ($urandom_range(0, 7) == 0);
                1:       cw = ($urandom_range(0, 1) == 0);
                2:       cw = ($urandom_range(0, 7) != 0);
                default: cw = 1'b0;
            endcase
            step(1'($urandom_range(0, 1)), cw, ($urandom_range(0, 60) == 0),
                 16'h4000 + 16'($urandom_range(0, 7)), 8'($urandom),
                 16'h4000 + 16'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
